regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters and tracks pending long-latency destinations. Requester 0 is the single-cycle ALU path; requester 1 is the long-latency path (load/mul-div). A 32-entry busy scoreboard drives the decode-stage stall for RAW hazards on pending long-latency writes. Sits between the execute/memory writeback sources and the register file write port.

---
 rtl/regfile_wb_arbiter_if.sv | 19 +
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 tb/tb_regfile_wb_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request/ready bundle for the two requesters
interface regfile_wb_arbiter_if;
  logic        wb0_valid;
  logic        wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid;
  logic        wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  wb0_ready, wb1_ready
  );
  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output wb0_ready, wb1_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and long-latency writeback, with busy scoreboard.
// WB_FORWARD_EN adds fwd1/fwd2 ports and clears busy at the wb1 transfer edge instead of the commit edge.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 issue_ready,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 stall,
  output logic [4:0]           write_reg,
  output logic [31:0]          write_data,
  output logic                 reg_write
`ifdef WB_FORWARD_EN
  ,
  output logic                 fwd1_hit,
  output logic                 fwd2_hit,
  output logic [31:0]          fwd1_data,
  output logic [31:0]          fwd2_data
`endif
);
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] busy, busy_nxt, set_m, clr_m;
  logic        xfer, xfer1;
  logic [4:0]  g_rd;
  logic [31:0] g_data;
  assign wb.wb1_ready = wb.wb1_valid && (!wb.wb0_valid || cnt == 4'(STARVE_LIMIT));
  assign wb.wb0_ready = wb.wb0_valid && !wb.wb1_ready;
  assign xfer1 = wb.wb1_valid && wb.wb1_ready;
  assign xfer = xfer1 || (wb.wb0_valid && wb.wb0_ready);
  assign g_rd = xfer1 ? wb.wb1_rd : wb.wb0_rd;
  assign g_data = xfer1 ? wb.wb1_data : wb.wb0_data;
  assign issue_ready = !busy[issue_rd];
  assign stall = busy[rs1] || busy[rs2];
`ifdef WB_FORWARD_EN
  assign fwd1_hit = reg_write && write_reg == rs1;
  assign fwd2_hit = reg_write && write_reg == rs2;
  assign fwd1_data = write_data;
  assign fwd2_data = write_data;
  assign clr_m = (xfer1 && wb.wb1_rd != 5'd0) ? 32'd1 << wb.wb1_rd : '0;
`else
  logic commit1;
  assign clr_m = commit1 ? 32'd1 << write_reg : '0;
`endif
  always_comb begin
    set_m = (issue_valid && issue_ready) ? 32'd1 << issue_rd : '0;
    busy_nxt = ((busy & ~clr_m) | set_m) & ~32'd1;
    cnt_nxt = (!wb.wb1_valid || xfer1) ? 4'd0 : (cnt == 4'(STARVE_LIMIT) ? cnt : cnt + 4'd1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      busy <= '0;
      reg_write <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
`ifndef WB_FORWARD_EN
      commit1 <= 1'b0;
`endif
    end else begin
      cnt <= cnt_nxt;
      busy <= busy_nxt;
      reg_write <= xfer && g_rd != 5'd0;
      if (xfer) begin
        write_reg <= g_rd;
        write_data <= g_data;
      end
`ifndef WB_FORWARD_EN
      commit1 <= xfer1 && wb.wb1_rd != 5'd0;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random writeback/scoreboard traffic against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int LIM = 4;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if wbif();
  logic issue_valid, issue_ready, stall, reg_write;
  logic [4:0] issue_rd, rs1, rs2, write_reg;
  logic [31:0] write_data;
`ifdef WB_FORWARD_EN
  logic fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif
  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .wb(wbif),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write)
`ifdef WB_FORWARD_EN
    , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );
  int checks = 0;
  int errors = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  bit mbusy[32];
  int starve, m_commit;
  bit m_rw;
  logic [4:0] m_wr;
  logic [31:0] m_wd;
  logic obs0, obs1, obsir, obsst;
  task automatic model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    starve = 0;
    m_commit = -1;
    m_rw = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask
  task automatic idle();
    wbif.wb0_valid = 0; wbif.wb0_rd = 0; wbif.wb0_data = 0;
    wbif.wb1_valid = 0; wbif.wb1_rd = 0; wbif.wb1_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask
  task automatic step(string tag);
    bit e0, e1, eir, est;
    #2;
    e1 = wbif.wb1_valid && (!wbif.wb0_valid || starve >= LIM);
    e0 = wbif.wb0_valid && !e1;
    eir = issue_rd == 0 || !mbusy[issue_rd];
    est = (rs1 != 0 && mbusy[rs1]) || (rs2 != 0 && mbusy[rs2]);
    obs0 = wbif.wb0_ready; obs1 = wbif.wb1_ready; obsir = issue_ready; obsst = stall;
    check({tag, ".wb0_ready"}, obs0, e0);
    check({tag, ".wb1_ready"}, obs1, e1);
    check({tag, ".issue_ready"}, obsir, eir);
    check({tag, ".stall"}, obsst, est);
    if (FWD) begin
      if (e1 && wbif.wb1_rd != 0) mbusy[wbif.wb1_rd] = 1'b0;
    end else begin
      if (m_commit > 0) mbusy[m_commit] = 1'b0;
      m_commit = (e1 && wbif.wb1_rd != 0) ? int'(wbif.wb1_rd) : -1;
    end
    if (issue_valid && eir && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    starve = (!wbif.wb1_valid || e1) ? 0 : (starve < LIM ? starve + 1 : LIM);
    if (e0 || e1) begin
      m_wr = e1 ? wbif.wb1_rd : wbif.wb0_rd;
      m_wd = e1 ? wbif.wb1_data : wbif.wb0_data;
      m_rw = m_wr != 0;
    end else m_rw = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".reg_write"}, reg_write, m_rw);
    check({tag, ".write_reg"}, write_reg, m_wr);
    check({tag, ".write_data"}, write_data, m_wd);
`ifdef WB_FORWARD_EN
    check({tag, ".fwd1_hit"}, fwd1_hit, m_rw && m_wr == rs1);
    check({tag, ".fwd2_hit"}, fwd2_hit, m_rw && m_wr == rs2);
    check({tag, ".fwd1_data"}, fwd1_data, m_wd);
`endif
  endtask
  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    check("rst.reg_write", reg_write, 0);
    check("rst.write_reg", write_reg, 0);
    check("rst.write_data", write_data, 0);
    check("rst.issue_ready", issue_ready, 1);
    for (int r = 1; r < 32; r++) begin
      rs1 = 5'(r);
      #1;
      check("rst.stall_sweep", stall, 0);
    end
    rs1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wbif.wb0_valid = 1; wbif.wb0_rd = 5; wbif.wb0_data = 32'hDEADBEEF;
    step("alu");
    check("alu.ready0", obs0, 1);
    check("alu.rw", reg_write, 1);
    check("alu.wr", write_reg, 5);
    check("alu.wd", write_data, 32'hDEADBEEF);
    idle();
    step("idle");
    wbif.wb0_valid = 1; wbif.wb0_rd = 1; wbif.wb0_data = 32'h11;
    wbif.wb1_valid = 1; wbif.wb1_rd = 2; wbif.wb1_data = 32'h22;
    for (int i = 1; i <= 10; i++) begin
      step("starve");
      check("starve.grant1", obs1, (i == 5 || i == 10));
    end
    idle();
    issue_valid = 1; issue_rd = 7;
    step("iss7");
    idle(); rs1 = 7;
    step("iss7.stall");
    check("iss7.stall_hi", obsst, 1);
    issue_valid = 1; issue_rd = 7;
    step("iss7.retry");
    check("iss7.retry_blocked", obsir, 0);
    idle(); rs1 = 7;
    wbif.wb1_valid = 1; wbif.wb1_rd = 7; wbif.wb1_data = 32'hCAFE0007;
    step("wb7");
    idle(); rs1 = 7;
    #1;
    check("wb7.stall_after_xfer", stall, FWD ? 0 : 1);
`ifdef WB_FORWARD_EN
    check("wb7.fwd1_hit", fwd1_hit, 1);
`endif
    step("wb7.commit");
    check("wb7.stall_after_commit", stall, 0);
    idle();
    wbif.wb1_valid = 1; wbif.wb1_rd = 0; wbif.wb1_data = 32'h1234;
    step("wb_r0");
    check("wb_r0.ready1", obs1, 1);
    check("wb_r0.rw", reg_write, 0);
    idle(); issue_valid = 1; issue_rd = 0;
    step("iss0");
    check("iss0.ready", obsir, 1);
    check("iss0.stall", obsst, 0);
    idle();
    wbif.wb1_valid = 1; wbif.wb1_rd = 9; wbif.wb1_data = 32'h99;
    step("wb9");
    idle(); issue_valid = 1; issue_rd = 9; rs2 = 9;
    step("set_wins");
    idle(); rs2 = 9;
    #1;
    check("set_wins.stall", stall, 1);
    step("set_wins.hold");
    idle(); issue_valid = 1; issue_rd = 3;
    step("iss3");
    idle(); wbif.wb1_valid = 1; wbif.wb1_rd = 3; wbif.wb1_data = 32'h33;
    step("wb3");
    idle(); rs1 = 3; issue_rd = 3;
    rst = 1'b1;
    #1;
    check("midrst.reg_write", reg_write, 0);
    check("midrst.stall", stall, 0);
    check("midrst.issue_ready", issue_ready, 1);
    check("midrst.write_reg", write_reg, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wbif.wb0_valid = 1; wbif.wb0_rd = 4; wbif.wb1_valid = 1; wbif.wb1_rd = 6;
    for (int i = 1; i <= 5; i++) begin
      step("midrst.cnt");
      check("midrst.grant1", obs1, i == 5);
    end
    for (int n = 0; n < 600; n++) begin
      wbif.wb0_valid = $urandom_range(0, 3) != 0;
      wbif.wb0_rd = 5'($urandom_range(0, 7));
      wbif.wb0_data = $urandom;
      wbif.wb1_valid = $urandom_range(0, 2) != 0;
      wbif.wb1_rd = 5'($urandom_range(0, 7));
      wbif.wb1_data = $urandom;
      issue_valid = $urandom_range(0, 2) == 0;
      issue_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 31));
      step("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
